// File: rtl/mul_div_unit_pkg.sv
// Shared op codes and FSM encoding for the multiply/divide unit.
package mul_div_unit_pkg;

    localparam logic [2:0] MD_OP_MULT  = 3'b000;
    localparam logic [2:0] MD_OP_MULTU = 3'b001;
    localparam logic [2:0] MD_OP_DIV   = 3'b010;
    localparam logic [2:0] MD_OP_DIVU  = 3'b011;
    localparam logic [2:0] MD_OP_MTHI  = 3'b100;
    localparam logic [2:0] MD_OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_datapath.sv
// Iterative shift-add multiply / restoring divide over unsigned magnitudes.
module md_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_mag_i,
    input  logic [WIDTH-1:0] b_mag_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   diff;

    // r holds product-high / remainder, q holds product-low / quotient
    always_comb begin
        r_d  = r_q;
        q_d  = q_q;
        m_d  = m_q;
        sum  = {1'b0, r_q} + (q_q[0] ? {1'b0, m_q} : '0);
        shl  = {r_q, q_q[WIDTH-1]};
        diff = shl - {1'b0, m_q};
        if (load_i) begin
            r_d = '0;
            m_d = is_div_i ? b_mag_i : a_mag_i;
            q_d = is_div_i ? a_mag_i : b_mag_i;
        end else if (step_i) begin
            if (is_div_i) begin
                if (!diff[WIDTH]) begin
                    r_d = diff[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = shl[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_d = sum[WIDTH:1];
                q_d = {sum[0], q_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
            q_q <= '0;
            m_q <= '0;
        end else begin
            r_q <= r_d;
            q_q <= q_d;
            m_q <= m_d;
        end
    end

    assign hi_o = r_q;
    assign lo_o = q_q;

endmodule

// File: rtl/mul_div_unit.sv
// MIPS multi-cycle multiply/divide unit owning the HI/LO registers.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       MDOperation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             negr_q, negr_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] araw_q, araw_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             accept;
    logic             op_sgn;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] dp_hi, dp_lo;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0] quo_s, rem_s;

    assign accept = start && (state_q == IDLE) && !MDOperation[2];
    assign op_sgn = !MDOperation[0];
    assign a_neg  = op_sgn && a[WIDTH-1];
    assign b_neg  = op_sgn && b[WIDTH-1];
    // 0x80.. negates to itself, which is the correct unsigned magnitude
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;

    md_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .step_i  (state_q == CALC),
        .is_div_i(accept ? MDOperation[1] : is_div_q),
        .a_mag_i (a_mag),
        .b_mag_i (b_mag),
        .hi_o    (dp_hi),
        .lo_o    (dp_lo)
    );

    assign prod   = {dp_hi, dp_lo};
    assign prod_s = neg_q ? -prod : prod;
    assign quo_s  = neg_q ? -dp_lo : dp_lo;
    assign rem_s  = negr_q ? -dp_hi : dp_hi;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        dbz_d    = dbz_q;
        araw_d   = araw_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    unique case (MDOperation)
                        MD_OP_MULT, MD_OP_MULTU,
                        MD_OP_DIV, MD_OP_DIVU: begin
                            state_d  = CALC;
                            cnt_d    = '0;
                            is_div_d = MDOperation[1];
                            neg_d    = a_neg ^ b_neg;
                            negr_d   = a_neg;
                            dbz_d    = (b == '0);
                            araw_d   = a;
                        end
                        MD_OP_MTHI: hi_d = a;
                        MD_OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end else if (dbz_q) begin
                    hi_d = araw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            dbz_q    <= 1'b0;
            araw_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            dbz_q    <= dbz_d;
            araw_q   <= araw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
- Sits beside the single-cycle ALU and handles MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Results are read back through the hi/lo outputs for MFHI/MFLO.
- Controller stalls on busy via a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only when busy=0.
- MDOperation  input  3  operation code; sampled with start.
- a  input  WIDTH  rs operand (dividend or multiplicand); sampled with start.
- b  input  WIDTH  rt operand (divisor or multiplier); sampled with start.
- busy  output  1  iterative operation in progress.
- done  output  1  one-cycle pulse when HI/LO take a mult/div result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset are decided: one clock, clk; reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, hi=0, lo=0, state=IDLE, counter=0.
- rst wins over everything, including mid-operation: the result is discarded and no done pulse follows.
- Op codes: MULT=000, MULTU=001, DIV=010, DIVU=011, MTHI=100, MTLO=101. Codes 110 and 111 are no-ops.
- IDLE, start=1, op in MULT..DIVU:
  - Latch operands; for signed ops latch absolute values plus result sign flags.
  - Go to CALC with counter=0; busy=1 from the next cycle.
- IDLE, start=1, MTHI/MTLO: hi<=a (or lo<=a) at that edge. busy and done stay 0; single cycle.
- CALC, exactly WIDTH cycles:
  - Multiply: radix-2 shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - After the WIDTH-th iteration go to FIX.
- FIX, 1 cycle: apply signs.
  - Signed product negated if the operand signs differ.
  - Signed quotient negated if the signs differ; remainder takes the sign of the dividend.
  - Next edge: hi/lo written, done=1 for exactly that cycle, busy=0, state=IDLE.
- Latency: start sampled at edge k → busy high in cycles k+1..k+WIDTH+1 → hi/lo valid and done=1 in cycle k+WIDTH+2 (34 for WIDTH=32).
- start while busy=1 is ignored entirely; operands and op are not re-sampled.
- start in the same cycle as done is accepted normally, since busy=0 in that cycle.
- hi/lo keep their old values throughout CALC and FIX; there are no partial updates.
- Result placement:
  - MULT/MULTU: hi=upper WIDTH bits, lo=lower WIDTH bits of the 2*WIDTH product.
  - DIV/DIVU: lo=quotient, hi=remainder.
- Divide by zero (b=0) completes with normal latency: lo=all ones, hi=a (unsigned raw dividend). No exception.
- Signed overflow, DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- Absolute-value handling must give the correct result for a or b = 0x80000000; use a WIDTH+1 internal magnitude if needed.

Decomposition:
- Shared package / define include:
  - MD_OP_* op-code constants, alongside the existing ALU op defines.
  - State encoding constants: IDLE, CALC, FIX.
- One natural sub-module, md_datapath:
  - Holds the accumulator and remainder/quotient shift registers plus per-iteration add/subtract.
  - Driven by the FSM, counter and sign flags in mul_div_unit.

Test Plan:
- Reset then idle → hi=0, lo=0, busy=0, done=0.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done at cycle k+34; hi=0xFFFFFFFE, lo=0x00000001. busy high exactly 33 cycles; a second start mid-operation is ignored.
- MULT a=-3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 → lo=14, hi=2.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234, normal latency. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0xCAFEBABE then MTLO a=0x12345678 on consecutive cycles → hi and lo updated the next edge each, no done pulse. Then:
  - Start MULT, assert rst at cycle k+10 → all outputs 0, no done.
  - Back-to-back start on the done cycle is accepted.
